// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the MEM-stage CPU port and a DMA port,
// with a DMA lock (forced timeout), registered read return and CPU stall accounting.
module dm_port_arbiter #(
  parameter int unsigned DM_WORDS = 3072,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [31:0] c_pc,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  output logic        cpu_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_lock,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  output logic        dm_we,
  input  logic [31:0] dm_rd,
  output logic [31:0] stall_cnt
);

  localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state;
  logic              last;  // 0 = CPU won last, 1 = DMA won last
  logic [CntW-1:0]   lock_cnt;
  logic              c_in_range;
  logic              d_in_range;

  assign c_in_range = c_addr[31:2] < 30'(DM_WORDS);
  assign d_in_range = d_addr[31:2] < 30'(DM_WORDS);

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (state == StLocked) begin
        d_gnt = d_req;
      end else if (c_req && d_req) begin
        c_gnt = last;
        d_gnt = ~last;
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end
  end

  always_comb begin
    dm_addr = 32'd0;
    dm_wd   = 32'd0;
    dm_pc   = 32'd0;
    if (c_gnt) begin
      dm_addr = c_addr;
      dm_wd   = c_wdata;
      dm_pc   = c_pc;
    end else if (d_gnt) begin
      dm_addr = d_addr;
      dm_wd   = d_wdata;
    end
  end

  assign dm_we     = ((c_gnt & c_we & c_in_range) | (d_gnt & d_we & d_in_range)) & reset;
  assign cpu_stall = c_req & ~c_gnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= StIdle;
      last      <= 1'b1;
      lock_cnt  <= '0;
      stall_cnt <= 32'd0;
      c_rvalid  <= 1'b0;
      c_err     <= 1'b0;
      c_rdata   <= 32'd0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 32'd0;
    end else begin
      c_rvalid <= c_gnt;
      c_err    <= c_gnt & ~c_in_range;
      c_rdata  <= (c_gnt && !c_we && c_in_range) ? dm_rd : 32'd0;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt & ~d_in_range;
      d_rdata  <= (d_gnt && !d_we && d_in_range) ? dm_rd : 32'd0;

      if (cpu_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      if (c_gnt) begin
        last <= 1'b0;
      end else if (d_gnt) begin
        last <= 1'b1;
      end

      // Leaving LOCKED overrides the grant update so the CPU wins the next tie.
      case (state)
        StIdle: begin
          if (d_gnt && d_lock) begin
            state    <= StLocked;
            lock_cnt <= '0;
          end
        end
        StLocked: begin
          if (!d_lock || (lock_cnt == CntW'(LOCK_MAX - 1))) begin
            state    <= StIdle;
            last     <= 1'b1;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: grants checked before each edge, results checked against
// a scoreboard of expected responses one cycle later. A simple memory stands in for DM.
module tb_dm_port_arbiter;

  logic        clk;
  logic        reset;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, c_pc, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, cpu_stall;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata, dm_addr, dm_wd, dm_pc, dm_rd, stall_cnt;
  logic        dm_we;

  logic [31:0] mem [0:4095];

  typedef struct packed {
    logic        port;  // 0 = CPU, 1 = DMA
    logic        err;
    logic [31:0] rdata;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dm_port_arbiter #(.DM_WORDS(3072), .LOCK_MAX(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_pc      (c_pc),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .c_err     (c_err),
    .cpu_stall (cpu_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_lock    (d_lock),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .dm_addr   (dm_addr),
    .dm_wd     (dm_wd),
    .dm_pc     (dm_pc),
    .dm_we     (dm_we),
    .dm_rd     (dm_rd),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dm_rd = mem[dm_addr[13:2]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[13:2]] <= dm_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick(input logic ec, input logic ed, input logic ewe,
                      input logic [31:0] erd, input logic eerr);
    res_t r;
    #1;
    chk("c_gnt", 32'(c_gnt), 32'(ec));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("dm_we", 32'(dm_we), 32'(ewe));
    chk("cpu_stall", 32'(cpu_stall), 32'(c_req & ~ec));
    chk("dm_pc", dm_pc, ec ? c_pc : 32'd0);
    chk("dm_addr", dm_addr, ec ? c_addr : (ed ? d_addr : 32'd0));
    chk("dm_wd", dm_wd, ec ? c_wdata : (ed ? d_wdata : 32'd0));
    if (ec || ed) sb.push_back('{port: ed, err: eerr, rdata: erd});
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk("c_rvalid", 32'(c_rvalid), 32'(r.port == 1'b0));
      chk("d_rvalid", 32'(d_rvalid), 32'(r.port == 1'b1));
      chk("rdata", r.port ? d_rdata : c_rdata, r.rdata);
      chk("err", 32'(r.port ? d_err : c_err), 32'(r.err));
    end else begin
      chk("c_rvalid_idle", 32'(c_rvalid), 32'd0);
      chk("d_rvalid_idle", 32'(d_rvalid), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    reset   = 1'b0;
    c_req   = 1'b1; c_we = 1'b0; c_addr = 32'h20; c_wdata = 32'h0; c_pc = 32'h400;
    d_req   = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0; d_lock = 1'b0;
    @(negedge clk);

    // Reset: grants held off, registers cleared.
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_c_err", 32'(c_err), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    // Contention from reset: CPU first, then alternate.
    reset = 1'b1;
    c_we = 1'b0; c_addr = 32'h20;
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
    end
    chk("stall_cnt_rr", stall_cnt, 32'd3);

    // DMA write then CPU read-back.
    c_req = 1'b0;
    d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    tick(1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
    d_req = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    tick(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Lock held for 4 DMA grants, CPU waits until the cycle after the lock drops.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hA5A5_0044; d_lock = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
    d_req = 1'b0; d_lock = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Lock held indefinitely: entry grant plus 16 locked grants, then CPU wins.
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1;
    for (int i = 0; i < 17; i++) tick(1'b0, 1'b1, 1'b0, 32'hA5A5_0044, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    d_lock = 1'b0;

    // Range boundary: out-of-range accesses are granted, flagged, and never write.
    c_req = 1'b0;
    d_addr = 32'hFFFF_FFFC;
    tick(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    d_req = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h3000; c_wdata = 32'h5;
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    c_addr = 32'h2FFC; c_wdata = 32'h77;
    tick(1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
    c_we = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 32'h77, 1'b0);

    // Reset in the middle of a lock.
    c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_lock = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 32'hA5A5_0044, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'hA5A5_0044, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'hA5A5_0044, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
